// File: rtl/adder_err_monitor.sv
// Sequential error evaluator for N-bit approximate adders: two-stage pipeline feeding saturating error metrics.
// Optional ADDER_ERR_SQ_EN adds a saturating sum of squared error magnitudes (sum_sq_err).
module adder_err_monitor #(
  parameter int W         = 8,
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [W:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W:0]       max_abs_err,
  output logic [W-1:0]     worst_a,
  output logic [W-1:0]     worst_b
`ifdef ADDER_ERR_SQ_EN
  ,
  output logic [2*ACC_W-1:0] sum_sq_err
`endif
);

  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int SW    = ((ACC_W > W + 1) ? ACC_W : W + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             drain_cnt;
  logic             accept;
  logic             clr;
  logic             last;

  // Unsigned magnitude of approx - exact; the difference needs one extra sign bit.
  function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
    logic signed [W+1:0] diff;
    diff = $signed({1'b0, x}) - $signed({1'b0, y});
    if (diff < 0) diff = -diff;
    return diff[W:0];
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [W:0] inc);
    logic [SW-1:0] s;
    s = SW'(acc) + SW'(inc);
    if (s > SW'({ACC_W{1'b1}})) return '1;
    return s[ACC_W-1:0];
  endfunction

  assign accept = in_valid && in_ready;
  assign clr    = start && (state == IDLE || state == DONE);
  assign last   = accept && (cnt == CNT_W'(N_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // DRAIN spans two cycles, matching the two pipeline stages still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (clr)         cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Stage 1: error magnitude and operands of the accepted sample
  logic           vld_p0;
  logic [W:0]     d_p0;
  logic           neq_p0;
  logic [W-1:0]   a_p0;
  logic [W-1:0]   b_p0;
  logic [W:0]     exact;

  assign exact = {1'b0, op_a} + {1'b0, op_b};

  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    d_p0   <= abs_diff(approx_sum, exact);
    neq_p0 <= (approx_sum != exact);
    a_p0   <= op_a;
    b_p0   <= op_b;
  end

`ifdef ADDER_ERR_SQ_EN
  localparam int SQW = ((2 * ACC_W > 2 * W + 2) ? 2 * ACC_W : 2 * W + 2) + 1;
  logic [2*W+1:0] dsq;

  function automatic logic [2*ACC_W-1:0] sat_add_sq(input logic [2*ACC_W-1:0] acc,
                                                    input logic [2*W+1:0] inc);
    logic [SQW-1:0] s;
    s = SQW'(acc) + SQW'(inc);
    if (s > SQW'({(2 * ACC_W){1'b1}})) return '1;
    return s[2*ACC_W-1:0];
  endfunction

  assign dsq = (2 * W + 2)'(d_p0) * (2 * W + 2)'(d_p0);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) sum_sq_err <= '0;
    else if (vld_p0)   sum_sq_err <= sat_add_sq(sum_sq_err, dsq);
  end
`endif

  // Stage 2: metric accumulation; strict > keeps the earliest worst-case operands on ties
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      worst_a     <= '0;
      worst_b     <= '0;
    end else if (vld_p0) begin
      err_count   <= sat_add(err_count, (W + 1)'(neq_p0));
      sum_abs_err <= sat_add(sum_abs_err, d_p0);
      if (d_p0 > max_abs_err) begin
        max_abs_err <= d_p0;
        worst_a     <= a_p0;
        worst_b     <= b_p0;
      end
    end
  end

endmodule

// File: tb/tb_adder_err_monitor.sv
// Directed bench for adder_err_monitor: table-driven runs on a 4-sample instance,
// hand sequences for gaps/drain/restart/abort, and a narrow-accumulator instance for saturation.
module tb_adder_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_start, a_in_valid, a_in_ready, a_busy, a_done;
  logic [7:0]  a_op_a, a_op_b, a_wa, a_wb;
  logic [8:0]  a_approx, a_max;
  logic [31:0] a_ec, a_se;

  logic        b_start, b_in_valid, b_in_ready, b_busy, b_done;
  logic [7:0]  b_op_a, b_op_b, b_wa, b_wb;
  logic [8:0]  b_approx, b_max;
  logic [3:0]  b_ec, b_se;
`ifdef ADDER_ERR_SQ_EN
  logic [63:0] a_sq;
  logic [7:0]  b_sq;
`endif

  adder_err_monitor #(.W(8), .N_SAMPLES(4), .ACC_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op_a(a_op_a), .op_b(a_op_b), .approx_sum(a_approx), .busy(a_busy), .done(a_done),
    .err_count(a_ec), .sum_abs_err(a_se), .max_abs_err(a_max), .worst_a(a_wa), .worst_b(a_wb)
`ifdef ADDER_ERR_SQ_EN
    , .sum_sq_err(a_sq)
`endif
  );

  adder_err_monitor #(.W(8), .N_SAMPLES(20), .ACC_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op_a(b_op_a), .op_b(b_op_b), .approx_sum(b_approx), .busy(b_busy), .done(b_done),
    .err_count(b_ec), .sum_abs_err(b_se), .max_abs_err(b_max), .worst_a(b_wa), .worst_b(b_wb)
`ifdef ADDER_ERR_SQ_EN
    , .sum_sq_err(b_sq)
`endif
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
  } smp_t;

  typedef struct packed {
    smp_t [3:0]  v;
    logic [31:0] ec;
    logic [31:0] se;
    logic [8:0]  mx;
    logic [7:0]  wa;
    logic [7:0]  wb;
  } run_t;

  run_t runs[4];
  int   total  = 0;
  int   passed = 0;

  function automatic smp_t S(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
    return {a, b, s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic feed_a(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
    a_op_a = a; a_op_b = b; a_approx = s; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic wait_done_a(input string nm);
    int n = 0;
    while (!a_done && n < 10) begin
      step();
      n++;
    end
    chk({nm, "_done"}, a_done, 1);
  endtask

  task automatic chk_metrics_a(input string nm, input logic [31:0] ec, input logic [31:0] se,
                               input logic [8:0] mx, input logic [7:0] wa, input logic [7:0] wb);
    chk({nm, "_err_count"}, a_ec, ec);
    chk({nm, "_sum_abs_err"}, a_se, se);
    chk({nm, "_max_abs_err"}, a_max, mx);
    chk({nm, "_worst_a"}, a_wa, wa);
    chk({nm, "_worst_b"}, a_wb, wb);
  endtask

  initial begin
    // Vectors listed in feed order: first sample leftmost
    runs[0] = '{v: {S(8'h0F, 8'h01, 9'h010), S(8'hFF, 8'hFF, 9'h1FE), S(8'h00, 8'h00, 9'h000), S(8'h80, 8'h80, 9'h100)},
                ec: 0, se: 0, mx: 9'd0, wa: 8'h00, wb: 8'h00};
    runs[1] = '{v: {S(8'h0F, 8'h01, 9'h000), S(8'hFF, 8'hFF, 9'h1FF), S(8'h00, 8'h00, 9'h000), S(8'h80, 8'h80, 9'h100)},
                ec: 2, se: 17, mx: 9'd16, wa: 8'h0F, wb: 8'h01};
    runs[2] = '{v: {S(8'h10, 8'h10, 9'h025), S(8'h03, 8'h04, 9'h002), S(8'h01, 8'h01, 9'h002), S(8'h00, 8'h00, 9'h000)},
                ec: 2, se: 10, mx: 9'd5, wa: 8'h10, wb: 8'h10};
    runs[3] = '{v: {S(8'h01, 8'h01, 9'h003), S(8'h20, 8'h20, 9'h000), S(8'h30, 8'h10, 9'h000), S(8'hFF, 8'h01, 9'h1FF)},
                ec: 4, se: 384, mx: 9'd255, wa: 8'hFF, wb: 8'h01};

    rst_n = 1'b0;
    a_start = 1'b1; a_in_valid = 1'b0; a_op_a = '0; a_op_b = '0; a_approx = '0;
    b_start = 1'b1; b_in_valid = 1'b0; b_op_a = '0; b_op_b = '0; b_approx = '0;
    repeat (3) step();
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk_metrics_a("rst", 0, 0, 0, 0, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_sum", b_se, 0);
    rst_n = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    step();
    chk("idle_in_ready", a_in_ready, 0);

    for (int i = 0; i < 4; i++) begin
      start_a();
      chk($sformatf("run%0d_busy_start", i), a_busy, 1);
      for (int j = 3; j >= 0; j--) feed_a(runs[i].v[j].a, runs[i].v[j].b, runs[i].v[j].s);
      wait_done_a($sformatf("run%0d", i));
      chk($sformatf("run%0d_busy_end", i), a_busy, 0);
      chk_metrics_a($sformatf("run%0d", i), runs[i].ec, runs[i].se, runs[i].mx, runs[i].wa, runs[i].wb);
`ifdef ADDER_ERR_SQ_EN
      if (i == 1) chk("run1_sum_sq_err", a_sq, 257);
`endif
    end

    // Ties with idle gaps, a start pulse mid-run, and the two-cycle drain
    start_a();
    feed_a(8'h10, 8'h10, 9'h025);
    step();
    step();
    chk("gap_latency_sum", a_se, 5);
    chk("gap_latency_err", a_ec, 1);
    chk("gap_in_ready", a_in_ready, 1);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("start_in_run_sum", a_se, 5);
    chk("start_in_run_busy", a_busy, 1);
    feed_a(8'h03, 8'h04, 9'h002);
    step();
    step();
    chk("gap_in_ready2", a_in_ready, 1);
    feed_a(8'h01, 8'h01, 9'h002);
    feed_a(8'h00, 8'h00, 9'h000);
    chk("drain1_in_ready", a_in_ready, 0);
    chk("drain1_busy", a_busy, 1);
    chk("drain1_done", a_done, 0);
    step();
    chk("drain2_done", a_done, 0);
    step();
    chk("drain_end_done", a_done, 1);
    chk("drain_end_busy", a_busy, 0);
    chk_metrics_a("gap", 2, 10, 5, 8'h10, 8'h10);
    step();
    chk("done_hold_sum", a_se, 10);

    start_a();
    chk("restart_done", a_done, 0);
    chk("restart_busy", a_busy, 1);
    chk_metrics_a("restart", 0, 0, 0, 0, 0);

    // Abort a run with non-zero metrics
    feed_a(8'h0F, 8'h01, 9'h000);
    feed_a(8'hFF, 8'hFF, 9'h1FF);
    step();
    chk("pre_abort_err", a_ec, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_busy", a_busy, 0);
    chk("abort_in_ready", a_in_ready, 0);
    chk_metrics_a("abort", 0, 0, 0, 0, 0);

    a_op_a = 8'h0F; a_op_b = 8'h01; a_approx = 9'h000; a_in_valid = 1'b1;
    repeat (3) step();
    a_in_valid = 1'b0;
    step();
    chk("idle_valid_err", a_ec, 0);
    chk("idle_valid_sum", a_se, 0);
    chk("idle_valid_busy", a_busy, 0);

    // Saturation on the 4-bit accumulator instance
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_op_a = 8'h00; b_op_b = 8'h00; b_approx = 9'h001;
    for (int k = 0; k < 20; k++) begin
      b_in_valid = 1'b1;
      step();
    end
    b_in_valid = 1'b0;
    begin
      int n = 0;
      while (!b_done && n < 10) begin
        step();
        n++;
      end
    end
    chk("sat_done", b_done, 1);
    chk("sat_sum_abs_err", b_se, 15);
    chk("sat_err_count", b_ec, 15);
    chk("sat_max_abs_err", b_max, 1);
    chk("sat_worst_a", b_wa, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
